// File: rtl/qupls_alu_wb_buffer_pkg.sv
// Shared types for the ALU writeback staging buffer: machine value type,
// fault codes, buffer FSM states and the buffered entry layout.

package cpu_types_pkg;
  typedef logic [63:0] value_t;
endpackage

package QuplsPkg;
  import cpu_types_pkg::*;

  localparam logic [7:0] FLT_NONE    = 8'h00;
  // Raised when a multiply/divide never signals completion.
  localparam logic [7:0] FLT_ALU_TMO = 8'h3E;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MUL = 2'd1,
    WAIT_DIV = 2'd2
  } alu_wb_state_t;

  typedef struct packed {
    logic [5:0] tag;
    value_t     res;
    logic [7:0] exc;
  } alu_wb_entry_t;
endpackage

// File: rtl/qupls_alu_wb_fifo.sv
// DEPTH-entry result FIFO with occupancy count; flush is a synchronous clear.
// Writes while full and reads while empty are dropped.

module qupls_alu_wb_fifo
  import QuplsPkg::*;
#(
  parameter int   DEPTH   = 4,
  parameter type  entry_t = alu_wb_entry_t,
  parameter entry_t RST_VAL = '0
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_flush,
  input  logic   i_wr,
  input  entry_t i_wr_data,
  input  logic   i_rd,
  output entry_t o_rd_data,
  output logic   o_full,
  output logic   o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t         r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;
  logic           w_push;
  logic           w_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push    = i_wr & ~o_full;
  assign w_pop     = i_rd & ~o_empty;
  assign o_rd_data = r_mem[r_rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= RST_VAL;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_wr_data;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/qupls_alu_wb_buffer.sv
// ALU result staging buffer feeding the writeback arbiter (wb_req/wb_grant).
// Optional multi-cycle watchdog enabled by `define QUPLS_ALU_WB_WATCHDOG_EN.

module qupls_alu_wb_buffer
  import QuplsPkg::*;
#(
  parameter int WID   = $bits(cpu_types_pkg::value_t),
  parameter int DEPTH = 4,
  parameter int TAGW  = 6,
  parameter int TMO   = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld,
  input  logic [TAGW-1:0] ld_tag,
  input  logic            ld_mul,
  input  logic            ld_div,
  input  logic [WID-1:0]  alu_o,
  input  logic [WID-1:0]  alu_exc,
  input  logic            mul_done,
  input  logic            div_done,
  input  logic            flush,
  input  logic            wb_grant,
  output logic            ready,
  output logic            wb_req,
  output logic [TAGW-1:0] wb_tag,
  output logic [WID-1:0]  wb_res,
  output logic [7:0]      wb_exc,
  output alu_wb_state_t   dbg_state
);

  localparam int NB = WID / 8;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TMO < 1 || (WID % 8) != 0) begin : g_param_chk
    $error("qupls_alu_wb_buffer: illegal parameter set");
  end

  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic [WID-1:0]  res;
    logic [7:0]      exc;
  } entry_t;

  localparam entry_t ENTRY_RST = '{tag: '0, res: '0, exc: FLT_NONE};

  // Lowest-indexed byte lane carrying a fault wins.
  function automatic logic [7:0] excsum(input logic [WID-1:0] exc);
    logic [7:0] sum;
    sum = FLT_NONE;
    for (int i = NB - 1; i >= 0; i--) begin
      if (exc[i*8 +: 8] != FLT_NONE) sum = exc[i*8 +: 8];
    end
    return sum;
  endfunction

  alu_wb_state_t   r_state;
  alu_wb_state_t   w_state_nxt;
  logic [TAGW-1:0] r_tag;
  logic            w_full;
  logic            w_empty;
  logic            w_ready;
  logic            w_ld;
  logic            w_enq;
  entry_t          w_enq_data;
  entry_t          w_head;

`ifdef QUPLS_ALU_WB_WATCHDOG_EN
  localparam int WCW = $clog2(TMO + 1);
  logic [WCW-1:0] r_wcnt;
  logic           w_tmo;

  // Counter sits at zero in IDLE, so it is clear on every WAIT_* entry.
  assign w_tmo = (r_wcnt == WCW'(TMO - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_wcnt <= '0;
    else if (r_state == IDLE) r_wcnt <= '0;
    else                    r_wcnt <= r_wcnt + WCW'(1);
  end
`endif

  assign w_ready   = (r_state == IDLE) & ~w_full;
  assign w_ld      = ld & w_ready;
  assign ready     = w_ready;
  assign dbg_state = r_state;

  always_comb begin
    w_state_nxt    = r_state;
    w_enq          = 1'b0;
    w_enq_data.tag = ld_tag;
    w_enq_data.res = alu_o;
    w_enq_data.exc = excsum(alu_exc);
    case (r_state)
      IDLE: begin
        if (w_ld) begin
          if (ld_mul)      w_state_nxt = WAIT_MUL;
          else if (ld_div) w_state_nxt = WAIT_DIV;
          else             w_enq       = 1'b1;
        end
      end
      WAIT_MUL, WAIT_DIV: begin
        w_enq_data.tag = r_tag;
        if ((r_state == WAIT_MUL) ? mul_done : div_done) begin
          w_enq       = 1'b1;
          w_state_nxt = IDLE;
        end
`ifdef QUPLS_ALU_WB_WATCHDOG_EN
        else if (w_tmo) begin
          w_enq          = 1'b1;
          w_enq_data.exc = FLT_ALU_TMO;
          w_state_nxt    = IDLE;
        end
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
    if (flush) begin
      w_state_nxt = IDLE;
      w_enq       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_tag   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ld && (ld_mul || ld_div)) r_tag <= ld_tag;
    end
  end

  qupls_alu_wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t),
    .RST_VAL (ENTRY_RST)
  ) u_fifo (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_flush   (flush),
    .i_wr      (w_enq),
    .i_wr_data (w_enq_data),
    .i_rd      (wb_grant),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign wb_req = ~w_empty;
  assign wb_tag = w_head.tag;
  assign wb_res = w_head.res;
  assign wb_exc = w_head.exc;

endmodule
